// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into a 32-bit instruction word and buffers it in a small output FIFO.
// Latency 1 cycle from push to head; in_ready = !full (registered), out_ready only pops.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.

module instr_encoder_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty when the indices match.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_raw,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);
  logic [31:0] enc_word;
  logic        enc_err;
  logic [32:0] head_dat;
  logic        full, empty, push, pop;
  logic [31:0] last_word;
  logic        last_err;

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_err  = 1'b0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
`endif
      end
      3'd2: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
`endif
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
`endif
      end
      3'd4: begin
        enc_word = {imm[31:12], rd, opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = |imm[11:0];
`endif
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
`endif
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full && !flush;
  assign pop       = out_valid && out_ready && !flush;

  instr_encoder_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .push     (push),
    .push_dat ({enc_err, enc_word}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  // Last delivered word is shown while the FIFO is empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_word <= '0;
      last_err  <= 1'b0;
      enc_count <= '0;
    end else if (pop) begin
      last_word <= head_dat[31:0];
      last_err  <= head_dat[32];
      enc_count <= enc_count + CNT_W'(1);
    end
  end

  assign instr_raw = out_valid ? head_dat[31:0] : last_word;
  assign out_err   = out_valid ? head_dat[32]   : last_err;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words, a negedge monitor checks every delivery.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, instr_raw;
  logic [15:0] enc_count;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_raw (instr_raw),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: every accepted output word must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got 0x%08h with no expectation queued", instr_raw);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word", instr_raw, e.word);
        check("err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  task automatic push(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input logic [31:0] ew, input logic ee);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back({ee, ew});
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    $display("FAIL push_timeout: in_ready stayed 0 for 200 cycles, expected 1");
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drained_queue", exp_q.size(), 0);
    check("drained_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  logic range_err;

  initial begin
`ifdef ENCODER_RANGE_CHECK_EN
    range_err = 1'b1;
`else
    range_err = 1'b0;
`endif
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_instr_raw", instr_raw, 32'h0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic encodings, consumer always ready.
    out_ready = 1'b1;
    push(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    push(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    push(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
    push(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    push(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h0000_0093, range_err);
    push(3'd7, 7'h33, 3'd1, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 32'h0000_0013, 1'b1);
    drain();
    check("enc_count_6", {16'd0, enc_count}, 32'd6);
    check("hold_instr_raw", instr_raw, 32'h0000_0013);
    check("hold_out_err", {31'd0, out_err}, 32'd1);

    // Backpressure: FIFO fills after two pushes, third waits for the consumer.
    out_ready = 1'b0;
    push(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    push(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    fork
      push(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0113, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("enc_count_9", {16'd0, enc_count}, 32'd9);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    push(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    push(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_enc_count", {16'd0, enc_count}, 32'd0);
    check("mid_rst_instr_raw", instr_raw, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush with two entries buffered.
    push(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
    push(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    check("pre_flush_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_enc_count", {16'd0, enc_count}, 32'd0);
    out_ready = 1'b1;
    push(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    drain();
    check("post_flush_enc_count", {16'd0, enc_count}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
